// File: rtl/etc_pkg.sv
// etc_pkg -- shared definitions for the ETC pixel writer.
//   IMG_W / BLK_PER_ROW : default image geometry (square image, 4x4 blocks)
//   FB_AW               : framebuffer word-address width
//   CNT_W               : width of the per-frame pixel counter
//   wr_state_e          : writer FSM state encoding
//   fmt_pixel()         : framebuffer data formatting.
// Optional feature macro: ETC_WRITER_ALPHA_EN keeps the decoded alpha byte;
// when it is undefined, alpha is forced to 8'hFF (opaque).
package etc_pkg;

    localparam int IMG_W       = 128;
    localparam int BLK_PER_ROW = 32;
    localparam int FB_AW       = 14;
    localparam int CNT_W       = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2,
        ST_DRAIN = 2'd3
    } wr_state_e;

    function automatic logic [31:0] fmt_pixel(input logic [31:0] rgba);
`ifdef ETC_WRITER_ALPHA_EN
        return rgba;
`else
        return {rgba[31:8], 8'hFF};
`endif
    endfunction

endpackage

// File: rtl/etc_fb_addr_gen.sv
// etc_fb_addr_gen -- combinational framebuffer address and range check.
//   blk_x, blk_y : block column / row
//   pix_idx      : pixel index inside the 4x4 block (column-major)
//   addr         : (blk_y*4+py)*IMG_W + blk_x*4+px, truncated to FB_AW bits
//   in_range     : 1 when block coordinates and pixel index are legal
module etc_fb_addr_gen
    import etc_pkg::*;
#(
    parameter int IMG_W       = etc_pkg::IMG_W,
    parameter int BLK_PER_ROW = etc_pkg::BLK_PER_ROW
) (
    input  logic [7:0]       blk_x,
    input  logic [7:0]       blk_y,
    input  logic [4:0]       pix_idx,
    output logic [FB_AW-1:0] addr,
    output logic             in_range
);

    logic [1:0] px;
    logic [1:0] py;

    always_comb begin
        // Column-major placement: upper index bits pick the column.
        px = pix_idx[3:2];
        py = pix_idx[1:0];
        // {blk,p} is exactly blk*4+p; evaluating in FB_AW bits gives the
        // required modulo-2^FB_AW truncation for free.
        addr = FB_AW'({blk_y, py}) * FB_AW'(IMG_W) + FB_AW'({blk_x, px});
        in_range = (32'(blk_x) < BLK_PER_ROW) &&
                   (32'(blk_y) < BLK_PER_ROW) &&
                   !pix_idx[4];
    end

endmodule

// File: rtl/etc_pixel_writer.sv
// etc_pixel_writer -- writes decoded ETC pixels into a linear framebuffer.
//   sclk, rsrt_n          : clock, asynchronous active-low reset
//   valid                 : request, held until write_finish is seen
//   blockX, blockY        : block coordinates of the pixel
//   pixIdx, pix_rgba      : pixel index in block, {R,G,B,A} data
//   write_finish          : one-cycle acknowledge
//   fb_we/fb_addr/fb_data : framebuffer write port
//   frame_done            : pulses with the ACK of the last pixel of a frame
//   idx_err               : sticky out-of-range flag, cleared by reset only
// Optional feature macro: ETC_WRITER_ALPHA_EN (pass alpha through unchanged).
module etc_pixel_writer
    import etc_pkg::*;
#(
    parameter int IMG_W       = etc_pkg::IMG_W,
    parameter int BLK_PER_ROW = etc_pkg::BLK_PER_ROW
) (
    input  logic             sclk,
    input  logic             rsrt_n,
    input  logic             valid,
    input  logic [7:0]       blockX,
    input  logic [7:0]       blockY,
    input  logic [4:0]       pixIdx,
    input  logic [31:0]      pix_rgba,
    output logic             write_finish,
    output logic             fb_we,
    output logic [FB_AW-1:0] fb_addr,
    output logic [31:0]      fb_data,
    output logic             frame_done,
    output logic             idx_err
);

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(IMG_W * IMG_W - 1);

    // Reset is asserted asynchronously but released only after two sclk
    // edges, so no state moves on the deassertion edge itself.
    logic rst_meta_q;
    logic rst_sync_n_q;

    always_ff @(posedge sclk or negedge rsrt_n) begin
        if (!rsrt_n) begin
            rst_meta_q   <= 1'b0;
            rst_sync_n_q <= 1'b0;
        end else begin
            rst_meta_q   <= 1'b1;
            rst_sync_n_q <= rst_meta_q;
        end
    end

    wr_state_e        state_q, state_d;
    logic [7:0]       blk_x_q, blk_x_d;
    logic [7:0]       blk_y_q, blk_y_d;
    logic [4:0]       pix_idx_q, pix_idx_d;
    logic [31:0]      data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             idx_err_q, idx_err_d;
    logic [FB_AW-1:0] addr;
    logic             in_range;
    logic             frame_last;

    etc_fb_addr_gen #(
        .IMG_W       (IMG_W),
        .BLK_PER_ROW (BLK_PER_ROW)
    ) u_addr_gen (
        .blk_x    (blk_x_q),
        .blk_y    (blk_y_q),
        .pix_idx  (pix_idx_q),
        .addr     (addr),
        .in_range (in_range)
    );

    assign frame_last = (cnt_q == FRAME_LAST);

    // State and datapath registers.
    always_ff @(posedge sclk or negedge rst_sync_n_q) begin
        if (!rst_sync_n_q) begin
            state_q   <= ST_IDLE;
            blk_x_q   <= '0;
            blk_y_q   <= '0;
            pix_idx_q <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            idx_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values; blocking here would create order-dependent races.
            state_q   <= state_d;
            blk_x_q   <= blk_x_d;
            blk_y_q   <= blk_y_d;
            pix_idx_q <= pix_idx_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            idx_err_q <= idx_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (valid) state_d = ST_WRITE;
            ST_WRITE: state_d = ST_ACK;
            ST_ACK:   state_d = ST_DRAIN;
            // Wait for the fetcher to drop valid so a held request is
            // never taken twice.
            ST_DRAIN: if (!valid) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: inputs are sampled only on the IDLE->WRITE edge.
    always_comb begin
        blk_x_d   = blk_x_q;
        blk_y_d   = blk_y_q;
        pix_idx_d = pix_idx_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        idx_err_d = idx_err_q;
        if (state_q == ST_IDLE && valid) begin
            blk_x_d   = blockX;
            blk_y_d   = blockY;
            pix_idx_d = pixIdx;
            data_d    = fmt_pixel(pix_rgba);
        end
        if (state_q == ST_WRITE && !in_range) begin
            idx_err_d = 1'b1;
        end
        // Dropped writes still count so the frame length stays fixed.
        if (state_q == ST_ACK) begin
            cnt_d = frame_last ? '0 : cnt_q + 1'b1;
        end
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        fb_we        = (state_q == ST_WRITE) && in_range;
        write_finish = (state_q == ST_ACK);
        frame_done   = (state_q == ST_ACK) && frame_last;
        fb_addr      = addr;
        fb_data      = data_q;
        idx_err      = idx_err_q;
    end

endmodule
